// File: rtl/rf_sequencer.sv
// Command-driven micro-sequencer for the 8-register file: expands one register
// operation at a time into cycle-by-cycle RF control, returning read data and done.
module rf_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [2:0]        cmd_dst,
  input  logic [2:0]        cmd_src,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [CNT_W-1:0]  cmd_cnt,
  output logic [1:0]        rf_funsel,
  output logic [3:0]        rf_rsel,
  output logic [3:0]        rf_tsel,
  output logic [2:0]        rf_o1sel,
  output logic [2:0]        rf_o2sel,
  output logic [DATA_W-1:0] rf_i,
  input  logic [DATA_W-1:0] rf_o1,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] OP_CLR = 3'd0;
  localparam logic [2:0] OP_LDI = 3'd1;
  localparam logic [2:0] OP_INC = 3'd2;
  localparam logic [2:0] OP_DEC = 3'd3;
  localparam logic [2:0] OP_MOV = 3'd4;
  localparam logic [2:0] OP_RD  = 3'd5;

  localparam logic [1:0] FS_CLR = 2'b00;
  localparam logic [1:0] FS_LD  = 2'b01;
  localparam logic [1:0] FS_DEC = 2'b10;
  localparam logic [1:0] FS_INC = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXEC   = 3'd1,
    S_MOV_RD = 3'd2,
    S_MOV_WR = 3'd3,
    S_RD     = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [2:0]          dst_q, dst_d;
  logic [2:0]          src_q, src_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hold_q, hold_d;

  logic                cmd_ready_q, cmd_ready_d;
  logic [1:0]          funsel_q, funsel_d;
  logic [3:0]          rsel_q, rsel_d;
  logic [3:0]          tsel_q, tsel_d;
  logic [2:0]          o1sel_q, o1sel_d;
  logic [2:0]          o2sel_q, o2sel_d;
  logic [DATA_W-1:0]   rf_i_q, rf_i_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                cnt_op_d;
  logic                wr_en_d;
  logic [3:0]          sel_d;

  // Next state, then outputs decoded from the next state so every output is a flop.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    dst_d       = dst_q;
    src_d       = src_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          dst_d  = cmd_dst;
          src_d  = cmd_src;
          data_d = cmd_data;
          cnt_d  = cmd_cnt;
          case (cmd_op)
            OP_CLR, OP_LDI, OP_INC, OP_DEC: state_d = S_EXEC;
            OP_MOV:                         state_d = S_MOV_RD;
            OP_RD:                          state_d = S_RD;
            default: begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end
          endcase
        end
      end
      S_EXEC: begin
        if ((op_q == OP_INC || op_q == OP_DEC) && cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d   = '0;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_MOV_RD: begin
        hold_d  = rf_o1;
        state_d = S_MOV_WR;
      end
      S_MOV_WR: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      S_RD: begin
        rsp_data_d  = rf_o1;
        rsp_valid_d = 1'b1;
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A zero repeat count keeps EXEC for one cycle but never enables a write.
    cnt_op_d = (op_d == OP_INC) || (op_d == OP_DEC);
    wr_en_d  = ((state_d == S_EXEC) && (!cnt_op_d || cnt_d != '0)) ||
               (state_d == S_MOV_WR);
    sel_d    = 4'b1000 >> dst_d[1:0];

    funsel_d = FS_CLR;
    rf_i_d   = '0;
    if (state_d == S_EXEC) begin
      case (op_d)
        OP_LDI: begin
          funsel_d = FS_LD;
          rf_i_d   = data_d;
        end
        OP_INC:  funsel_d = FS_INC;
        OP_DEC:  funsel_d = FS_DEC;
        default: funsel_d = FS_CLR;
      endcase
    end else if (state_d == S_MOV_WR) begin
      funsel_d = FS_LD;
      rf_i_d   = hold_d;
    end

    rsel_d      = (wr_en_d && dst_d[2])  ? sel_d : 4'b0000;
    tsel_d      = (wr_en_d && !dst_d[2]) ? sel_d : 4'b0000;
    o1sel_d     = src_d;
    o2sel_d     = dst_d;
    cmd_ready_d = (state_d == S_IDLE);
  end

  // State, command latches and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      dst_q       <= '0;
      src_q       <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      cmd_ready_q <= 1'b1;
      funsel_q    <= FS_CLR;
      rsel_q      <= '0;
      tsel_q      <= '0;
      o1sel_q     <= '0;
      o2sel_q     <= '0;
      rf_i_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      cmd_ready_q <= cmd_ready_d;
      funsel_q    <= funsel_d;
      rsel_q      <= rsel_d;
      tsel_q      <= tsel_d;
      o1sel_q     <= o1sel_d;
      o2sel_q     <= o2sel_d;
      rf_i_q      <= rf_i_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rf_funsel = funsel_q;
  assign rf_rsel   = rsel_q;
  assign rf_tsel   = tsel_q;
  assign rf_o1sel  = o1sel_q;
  assign rf_o2sel  = o2sel_q;
  assign rf_i      = rf_i_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rf_sequencer.sv
// Bench for rf_sequencer: behavioural RF attached to the control outputs, command-level
// reference model feeding a scoreboard popped by an output monitor.
module tb_rf_sequencer;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_op = '0, cmd_dst = '0, cmd_src = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic [CNT_W-1:0]  cmd_cnt = '0;
  logic [1:0]        rf_funsel;
  logic [3:0]        rf_rsel, rf_tsel;
  logic [2:0]        rf_o1sel, rf_o2sel;
  logic [DATA_W-1:0] rf_i, rf_o1, rsp_data;
  logic              rsp_valid, done, err;

  always #5 clk = ~clk;

  rf_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_data(cmd_data),
    .cmd_cnt(cmd_cnt), .rf_funsel(rf_funsel), .rf_rsel(rf_rsel), .rf_tsel(rf_tsel),
    .rf_o1sel(rf_o1sel), .rf_o2sel(rf_o2sel), .rf_i(rf_i), .rf_o1(rf_o1),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done), .err(err)
  );

  // Register file stand-in: ids 0..3 = T1..T4, 4..7 = R1..R4; not reset by rst_n.
  logic [7:0] rf_q [0:7] = '{8{8'h00}};
  assign rf_o1 = rf_q[rf_o1sel];

  function automatic logic [7:0] rf_apply(input logic [7:0] v, input logic [1:0] fs,
                                          input logic [7:0] din);
    case (fs)
      2'b00:   return 8'h00;
      2'b01:   return din;
      2'b10:   return 8'(v - 8'd1);
      default: return 8'(v + 8'd1);
    endcase
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rf_tsel[3-i]) rf_q[i]   <= rf_apply(rf_q[i],   rf_funsel, rf_i);
      if (rf_rsel[3-i]) rf_q[4+i] <= rf_apply(rf_q[4+i], rf_funsel, rf_i);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [2:0] dst;
    int         acc_cyc;
    int         lat;
    int         en_cyc;
    logic       err_e;
    logic       rv_e;
    logic [7:0] rd_e;
    logic [7:0] fin_e;
    logic [7:0] wd_e;
    logic       chk_fin;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ref_q [0:7] = '{8{8'h00}};
  int         last_acc = 0;

  // {rsel,tsel} bit for a register id: R1..R4 -> bits 7..4, T1..T4 -> bits 3..0.
  function automatic logic [7:0] sel_of(input logic [2:0] id);
    logic [7:0] one;
    one = 8'd1;
    return id[2] ? (one << (11 - int'(id))) : (one << (3 - int'(id)));
  endfunction

  function automatic logic [1:0] fs_of(input logic [2:0] op);
    case (op)
      3'd0:    return 2'b00;
      3'd2:    return 2'b11;
      3'd3:    return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  // Output monitor: per-cycle write checks and scoreboard pop on done.
  exp_t e;
  int   en_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      en_cnt = 0;
    end else begin
      if (rf_rsel != 4'b0 || rf_tsel != 4'b0) begin
        if (sb.size() == 0) begin
          fail_now("stray_enable");
        end else begin
          e = sb[0];
          en_cnt++;
          check("en_sel", {rf_rsel, rf_tsel}, sel_of(e.dst));
          check("funsel", rf_funsel, fs_of(e.op));
          if (e.op == 3'd1 || e.op == 3'd4) check("rf_i", rf_i, e.wd_e);
        end
      end
      if (rsp_valid && !done) fail_now("rsp_valid_without_done");
      if (done) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          e = sb.pop_front();
          check("latency", cyc - e.acc_cyc, e.lat);
          check("err", err, e.err_e);
          check("rsp_valid", rsp_valid, e.rv_e);
          if (e.rv_e) check("rsp_data", rsp_data, e.rd_e);
          check("en_cycles", en_cnt, e.en_cyc);
          if (e.chk_fin) check("rf_dst_value", rf_q[e.dst], e.fin_e);
        end
        en_cnt = 0;
      end
    end
  end

  // Issue one command; keep=1 leaves cmd_valid high for a back-to-back follow-up.
  task automatic send(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                      input logic [7:0] data, input logic [3:0] cnt, input bit keep);
    exp_t x;
    int   w;
    w = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_data = data; cmd_cnt = cnt;
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      fail_now("cmd_ready_timeout");
      cmd_valid = 1'b0;
      return;
    end
    x = '{op: op, dst: dst, acc_cyc: cyc, lat: 2, en_cyc: 1, err_e: 1'b0, rv_e: 1'b0,
          rd_e: 8'h00, fin_e: 8'h00, wd_e: 8'h00, chk_fin: 1'b1};
    case (op)
      3'd0: x.fin_e = 8'h00;
      3'd1: begin x.fin_e = data; x.wd_e = data; end
      3'd2: begin
        x.fin_e = 8'(ref_q[dst] + 8'(cnt));
        x.en_cyc = int'(cnt);
        x.lat = (cnt == 4'd0) ? 2 : int'(cnt) + 1;
      end
      3'd3: begin
        x.fin_e = 8'(ref_q[dst] - 8'(cnt));
        x.en_cyc = int'(cnt);
        x.lat = (cnt == 4'd0) ? 2 : int'(cnt) + 1;
      end
      3'd4: begin x.fin_e = ref_q[src]; x.wd_e = ref_q[src]; x.lat = 3; end
      3'd5: begin x.rd_e = ref_q[src]; x.rv_e = 1'b1; x.en_cyc = 0; x.chk_fin = 1'b0; end
      default: begin x.err_e = 1'b1; x.lat = 1; x.en_cyc = 0; x.chk_fin = 1'b0; end
    endcase
    if (x.chk_fin) ref_q[dst] = x.fin_e;
    last_acc = cyc;
    sb.push_back(x);
    @(posedge clk);
    if (!keep) begin
      #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) fail_now("done_timeout");
    @(negedge clk);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_funsel"},    rf_funsel, 0);
    check({tag, "_rsel"},      rf_rsel, 0);
    check({tag, "_tsel"},      rf_tsel, 0);
    check({tag, "_o1sel"},     rf_o1sel, 0);
    check({tag, "_o2sel"},     rf_o2sel, 0);
    check({tag, "_rf_i"},      rf_i, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"},  rsp_data, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_err"},       err, 0);
  endtask

  initial begin
    int prev;
    logic [7:0] t1_init;
    repeat (3) @(negedge clk);
    check_reset_outs("por");
    rst_n = 1'b1;

    // R1 load and read-back.
    send(3'd1, 3'd4, 3'd0, 8'h14, 4'd0, 0);
    send(3'd5, 3'd0, 3'd4, 8'h00, 4'd0, 0);
    // T2 decrement through zero.
    send(3'd1, 3'd1, 3'd0, 8'h02, 4'd0, 0);
    send(3'd3, 3'd1, 3'd0, 8'h00, 4'd3, 0);
    // Copies, including onto itself.
    send(3'd1, 3'd7, 3'd0, 8'h5A, 4'd0, 0);
    send(3'd4, 3'd2, 3'd7, 8'h00, 4'd0, 0);
    send(3'd1, 3'd5, 3'd0, 8'hC3, 4'd0, 0);
    send(3'd4, 3'd5, 3'd5, 8'h00, 4'd0, 0);
    // Zero-count increment and reserved opcode.
    send(3'd2, 3'd6, 3'd0, 8'h00, 4'd0, 0);
    send(3'd6, 3'd3, 3'd1, 8'hEE, 4'd5, 0);
    send(3'd7, 3'd0, 3'd0, 8'h00, 4'd0, 0);
    wait_idle();

    // Back-to-back loads with cmd_valid held high.
    send(3'd1, 3'd0, 3'd0, 8'h11, 4'd0, 1);
    for (int i = 1; i < 5; i++) begin
      prev = last_acc;
      send(3'd1, 3'(i + 2), 3'd0, 8'(8'h20 + 8'(i)), 4'd0, i != 4);
      check("b2b_spacing", last_acc - prev, 2);
    end
    wait_idle();

    // Reset in the middle of a long increment.
    send(3'd1, 3'd0, 3'd0, 8'hF8, 4'd0, 0);
    wait_idle();
    t1_init = ref_q[0];
    send(3'd2, 3'd0, 3'd0, 8'h00, 4'd15, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    ref_q[0] = 8'(t1_init + 8'd5);
    check_reset_outs("midrst");
    @(posedge clk);
    #1 check("midrst_T1", rf_q[0], ref_q[0]);
    check("midrst_no_write", rf_tsel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(3'd5, 3'd0, 3'd0, 8'h00, 4'd0, 0);
    wait_idle();

    // Randomized command mix.
    for (int i = 0; i < 80; i++) begin
      send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           8'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle();

    for (int i = 0; i < 8; i++) check($sformatf("final_reg%0d", i), rf_q[i], ref_q[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
